// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer onto a req/ack data-memory bus
// Lane steering, load extension, misalignment and timeout reporting.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        lat_store;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;

  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign stall = op_valid & (state != FINISH);

  always_comb begin
    misaligned = 1'b0;
    case (op_size)
      2'b01:   misaligned = op_addr[0];
      2'b10:   misaligned = |op_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be_n    = 4'b0000;
    wdata_n = 32'd0;
    case (op_size)
      2'b00: begin
        be_n    = 4'b0001 << op_addr[1:0];
        wdata_n = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{op_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = op_wdata;
      end
    endcase
  end

  // Load extraction works from the latched op, since op_* may change after acceptance is seen.
  always_comb begin
    byte_sel = 8'd0;
    case (lat_off)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_ext = 32'd0;
    if (!lat_store) begin
      case (lat_size)
        2'b00:   load_ext = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
        2'b01:   load_ext = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
        default: load_ext = bus_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      lat_store    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_off      <= 2'b00;
      done         <= 1'b0;
      rdata        <= 32'd0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (misaligned) begin
              state    <= FINISH;
              done     <= 1'b1;
              addr_err <= 1'b1;
            end else begin
              state        <= ACCESS;
              cnt          <= 32'd0;
              lat_store    <= op_store;
              lat_unsigned <= op_unsigned;
              lat_size     <= op_size;
              lat_off      <= op_addr[1:0];
              bus_req      <= 1'b1;
              bus_we       <= op_store;
              bus_addr     <= {op_addr[31:2], 2'b00};
              bus_be       <= be_n;
              bus_wdata    <= wdata_n;
            end
          end
        end
        ACCESS: begin
          // An ack arriving in the timeout cycle still completes the access normally.
          if (bus_ack || ((TIMEOUT != 0) && ((cnt + 32'd1) == 32'(TIMEOUT)))) begin
            state     <= FINISH;
            done      <= 1'b1;
            bus_err   <= ~bus_ack;
            rdata     <= bus_ack ? load_ext : 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          done     <= 1'b0;
          rdata    <= 32'd0;
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed bench for dmem_access_ctrl
// Instance uses TIMEOUT=4 so the timeout path is reachable in a few cycles.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall),
    .done(done), .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op at cycle 0; acks after 'waits' request cycles (-1 = never).
  task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, output int done_cyc, output int req_cyc,
                        output logic [31:0] rdat, output logic [3:0] be,
                        output logic [31:0] bwd, output logic [1:0] errs);
    done_cyc = -1;
    req_cyc  = 0;
    rdat     = 32'hDEAD_BEEF;
    be       = 4'b0000;
    bwd      = 32'd0;
    errs     = 2'b11;
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = un;
    op_addr = a; op_wdata = wd; bus_ack = 1'b0; bus_rdata = rd;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus_req) begin
        req_cyc++;
        be  = bus_be;
        bwd = bus_wdata;
      end
      bus_ack = bus_req && (req_cyc == waits + 1);
      if (done) begin
        done_cyc = c;
        rdat     = rdata;
        errs     = {addr_err, bus_err};
        chk("stall_low_at_done", stall, 1'b0);
        break;
      end
    end
    op_valid = 1'b0;
    bus_ack  = 1'b0;
    tick();
    chk("done_single_pulse", done, 1'b0);
    chk("req_low_after_done", bus_req, 1'b0);
  endtask

  int          dc;
  int          rc;
  logic [31:0] rv;
  logic [3:0]  bev;
  logic [31:0] wdv;
  logic [1:0]  ev;
  int          seen;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
    op_addr = 32'd0; op_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", bus_be, 4'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // SB a=0x1003: single-lane enable, replicated data
    run_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("sb_done_cycle", dc, 2);
    chk("sb_req_cycles", rc, 1);
    chk("sb_be", bev, 4'b1000);
    chk("sb_wdata", wdv, 32'hA5A5_A5A5);
    chk("sb_rdata", rv, 32'd0);
    chk("sb_errs", ev, 2'b00);

    // LH a=0x2002 signed, three wait cycles
    run_op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 3, 32'h8001_1234, dc, rc, rv, bev, wdv, ev);
    chk("lh_done_cycle", dc, 5);
    chk("lh_req_cycles", rc, 4);
    chk("lh_be", bev, 4'b1100);
    chk("lh_rdata", rv, 32'hFFFF_8001);
    chk("lh_errs", ev, 2'b00);

    run_op(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'd0, 0, 32'h0000_9F00, dc, rc, rv, bev, wdv, ev);
    chk("lbu_be", bev, 4'b0010);
    chk("lbu_rdata", rv, 32'h0000_009F);
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'd0, 0, 32'h0000_9F00, dc, rc, rv, bev, wdv, ev);
    chk("lb_rdata", rv, 32'hFFFF_FF9F);

    // Misaligned / illegal size: immediate addr_err, no bus cycle
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h1111_2222, 0, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("sw_mis_done_cycle", dc, 1);
    chk("sw_mis_req_cycles", rc, 0);
    chk("sw_mis_errs", ev, 2'b10);
    run_op(1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1111_2222, 0, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("sh_mis_done_cycle", dc, 1);
    chk("sh_mis_req_cycles", rc, 0);
    chk("sh_mis_errs", ev, 2'b10);
    run_op(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'd0, 0, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("size11_errs", ev, 2'b10);
    chk("size11_req_cycles", rc, 0);

    // Timeout: four request cycles, then bus_err
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, -1, 32'h5555_5555, dc, rc, rv, bev, wdv, ev);
    chk("to_req_cycles", rc, 4);
    chk("to_done_cycle", dc, 5);
    chk("to_errs", ev, 2'b01);
    chk("to_rdata", rv, 32'd0);

    run_op(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'hABCD_1234, 1, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("sh_be", bev, 4'b1100);
    chk("sh_wdata", wdv, 32'h1234_1234);
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_5000, 32'd0, 0, 32'h8001_F00D, dc, rc, rv, bev, wdv, ev);
    chk("lhu_be", bev, 4'b0011);
    chk("lhu_rdata", rv, 32'h0000_F00D);

    // Back-to-back SW then LW: second op accepted in the cycle after done
    run_op(1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hCAFE_F00D, 0, 32'd0, dc, rc, rv, bev, wdv, ev);
    chk("b2b_sw_wdata", wdv, 32'hCAFE_F00D);
    chk("b2b_sw_be", bev, 4'b1111);
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'd0, 0, 32'h1234_5678, dc, rc, rv, bev, wdv, ev);
    chk("b2b_lw_done_cycle", dc, 2);
    chk("b2b_lw_rdata", rv, 32'h1234_5678);

    // Reset during the second wait cycle drops the op
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'b10; op_addr = 32'h0000_6000;
    bus_ack = 1'b0;
    tick();
    chk("rst_mid_req_c1", bus_req, 1'b1);
    chk("rst_mid_addr", bus_addr, 32'h0000_6000);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_async", bus_req, 1'b0);
    op_valid = 1'b0;
    tick();
    rst = 1'b0;
    bus_ack = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || bus_req) seen++;
    end
    bus_ack = 1'b0;
    chk("rst_mid_no_done_no_req", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
